audio_sample_sched: RTL and testbench
=====================================

# audio_sample_sched

Sample scheduler for the audio datapath. It sequences the audio codec read and write handshakes one stereo sample at a time. It selects the sample source: live ADC passthrough, or a mono tone stored in an external registered ROM whose address it walks and wraps. It sits between the top-level switch and reset logic and the `audio_codec` instance, and replaces the direct `read = read_ready` / `write = write_ready` wiring.

## Interface
Parameters:
- `DATA_W`, 24: sample width, two's complement, per channel.
- `ADDR_W`, 16: tone ROM address width.
- `TONE_LEN`, 48000: number of valid ROM entries. Range 2..2^ADDR_W.

Ports:
- `CLOCK_50`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `src_sel`, in, 1: source select, asynchronous (board switch). 0 = ADC passthrough, 1 = tone ROM.
- `read_ready`, in, 1: codec has an ADC sample available.
- `write_ready`, in, 1: codec can accept a DAC sample.
- `readdata_left`, in, DATA_W: codec ADC left channel.
- `readdata_right`, in, DATA_W: codec ADC right channel.
- `rom_q`, in, DATA_W: tone ROM data. Registered ROM, valid 1 cycle after `rom_addr`.
- `read`, out, 1: codec read strobe.
- `write`, out, 1: codec write strobe.
- `writedata_left`, out, DATA_W: DAC left channel.
- `writedata_right`, out, DATA_W: DAC right channel.
- `rom_addr`, out, ADDR_W: tone ROM address.
- `tone_wrap`, out, 1: one-cycle pulse when `rom_addr` wraps.

## Operation
- `src_sel` passes through a 2-flop synchronizer; `sel_s` is the synchronized value.
- States: `FETCH`, `ROMWAIT`, `PUSH`. Reset state is `FETCH`.
- On entry to each sample, `FETCH` latches `sel_s` into `cur_sel`. `src_sel` changes during `ROMWAIT` or `PUSH` do not affect the current sample.
- `FETCH` with `cur_sel`=0:
  - `read` = `read_ready` (combinational, this state only).
  - When `read_ready`=1: capture `readdata_left` into `hold_l` and `readdata_right` into `hold_r`, then go to `PUSH`. Otherwise stay.
- `FETCH` with `cur_sel`=1:
  - `read`=0; `rom_addr` is already stable.
  - Go to `ROMWAIT` unconditionally.
- `ROMWAIT`: capture `rom_q` into both `hold_l` and `hold_r`, then go to `PUSH`.
- `PUSH`:
  - `write` = `write_ready` (combinational, this state only). `writedata_*` is stable for the whole state.
  - When `write_ready`=1, go to `FETCH`.
  - If `cur_sel`=1, advance `rom_addr` in the same cycle: `rom_addr` = `rom_addr`+1, or 0 when `rom_addr`=`TONE_LEN`-1. On wrap, `tone_wrap`=1 for the next cycle.
- `rom_addr` holds its value while in passthrough. Returning to tone resumes from the held address.
- `read` and `write` are never both 1 in the same cycle, and each is never high for more than 1 cycle per sample.
- Reset mid-operation (any state): next cycle `FETCH`, all outputs at reset values, and the current sample is dropped.

## Timing
- Reset values: `read`=0, `write`=0, `writedata_left`=0, `writedata_right`=0, `rom_addr`=0, `tone_wrap`=0, `hold_*`=0, `cur_sel`=0, synchronizer flops=0.
- Passthrough:
  - `read` pulse at cycle t.
  - `writedata_*` updated at t+1.
  - Earliest `write` at t+1.
  - Minimum 2 cycles per sample.
- Tone:
  - `FETCH` at t, `ROMWAIT` at t+1, `writedata_*` valid at t+2.
  - Earliest `write` at t+2.
  - Minimum 3 cycles per sample.
- `src_sel` to `sel_s` latency is 2 cycles; the new value takes effect at the next `FETCH` entry.
- `tone_wrap` is asserted in the cycle after the `write` that completes address `TONE_LEN`-1.

## Configuration
- `AUDIO_AVG_EN`:
  - When defined, `writedata_*` = (`hold_*` + `prev_*`) >>> 1. The sum is signed, DATA_W+1 bits, arithmetic shift, truncated to DATA_W.
  - `prev_*` takes `hold_*` on each `write` and resets to 0.
  - `prev_*` is cleared to 0 when `cur_sel` differs from its value at the previous sample.
- Undefined: `writedata_*` = `hold_*` directly, and no `prev_*` registers exist.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `read_ready`=`write_ready`=1. All outputs are 0 and no strobes are issued. After release, the first `read` occurs in the first cycle.
- Passthrough: `src_sel`=0, `readdata_left`=24'h000123, `readdata_right`=24'hFFFF00, `write_ready`=0 for 5 cycles, then 1.
  - Exactly one `read`.
  - `writedata` = 000123/FFFF00, held stable through the stall.
  - Exactly one `write`.
- Tone wrap: `TONE_LEN`=4, `src_sel`=1, ROM q = address×16, both ready signals held high.
  - Written samples: 0, 16, 32, 48, 0.
  - `tone_wrap` pulses once after the fourth write.
  - 3 cycles per sample.
- Source switch: toggle `src_sel` 0→1 while in `PUSH`. The current passthrough sample completes unchanged, and the tone starts at the held `rom_addr` from the second-next `FETCH`.
- Reset mid-`PUSH` with `write_ready`=0: no `write` is issued and `rom_addr` returns to 0.
- `AUDIO_AVG_EN`: passthrough samples 100 then 300 write 50, then 200. Samples -3 then -1 write -2 (from prev 0), then -2.

Source files
------------

// File: rtl/audio_sample_sched.sv
// Codec sample sequencer: ADC passthrough or tone ROM playback, one stereo sample at a time.
// Build option AUDIO_AVG_EN averages each DAC sample with the previous one.
module audio_sample_sched #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 16,
  parameter int TONE_LEN = 48000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              src_sel,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic [DATA_W-1:0] rom_q,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              tone_wrap
);

  typedef enum logic [1:0] {
    FETCH,
    ROMWAIT,
    PUSH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TONE_LEN - 1);

  state_t            state;
  logic              sync1;
  logic              sel_s;
  logic              cur_sel;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b0;
      sel_s <= 1'b0;
    end else begin
      sync1 <= src_sel;
      sel_s <= sync1;
    end
  end

`ifdef AUDIO_AVG_EN
  logic [DATA_W-1:0]      prev_l;
  logic [DATA_W-1:0]      prev_r;
  logic signed [DATA_W:0] sum_l;
  logic signed [DATA_W:0] sum_r;

  assign sum_l = $signed({hold_l[DATA_W-1], hold_l})
               + $signed({prev_l[DATA_W-1], prev_l});
  assign sum_r = $signed({hold_r[DATA_W-1], hold_r})
               + $signed({prev_r[DATA_W-1], prev_r});
  assign writedata_left  = DATA_W'(sum_l >>> 1);
  assign writedata_right = DATA_W'(sum_r >>> 1);
`else
  assign writedata_left  = hold_l;
  assign writedata_right = hold_r;
`endif

  // Strobes are gated by reset so nothing reaches the codec while held.
  assign read  = !reset && state == FETCH
              && !cur_sel && read_ready;
  assign write = !reset && state == PUSH
              && write_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= FETCH;
      cur_sel   <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      rom_addr  <= '0;
      tone_wrap <= 1'b0;
`ifdef AUDIO_AVG_EN
      prev_l    <= '0;
      prev_r    <= '0;
`endif
    end else begin
      tone_wrap <= 1'b0;
      unique case (state)
        FETCH: begin
          if (cur_sel) begin
            state <= ROMWAIT;
          end else if (read_ready) begin
            hold_l <= readdata_left;
            hold_r <= readdata_right;
            state  <= PUSH;
          end
        end
        ROMWAIT: begin
          hold_l <= rom_q;
          hold_r <= rom_q;
          state  <= PUSH;
        end
        PUSH: begin
          if (write_ready) begin
            state   <= FETCH;
            cur_sel <= sel_s;
`ifdef AUDIO_AVG_EN
            // A source change restarts the average from silence.
            prev_l  <= (sel_s != cur_sel) ? '0 : hold_l;
            prev_r  <= (sel_s != cur_sel) ? '0 : hold_r;
`endif
            if (cur_sel) begin
              if (rom_addr == LAST) begin
                rom_addr  <= '0;
                tone_wrap <= 1'b1;
              end else begin
                rom_addr <= rom_addr + 1'b1;
              end
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Bench for audio_sample_sched: directed scenarios plus random traffic
// checked against a sample-level scoreboard.
module tb_audio_sample_sched;

  localparam int DW = 24;
  localparam int AW = 16;
  localparam int TL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          src_sel = 1'b0;
  logic          read_ready = 1'b1;
  logic          write_ready = 1'b1;
  logic [DW-1:0] readdata_left = '0;
  logic [DW-1:0] readdata_right = '0;
  logic [DW-1:0] rom_q;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;
  logic [AW-1:0] rom_addr;
  logic          tone_wrap;

  int checks = 0;
  int failures = 0;

  audio_sample_sched #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TONE_LEN(TL)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .src_sel        (src_sel),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .rom_q          (rom_q),
    .read           (read),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .rom_addr       (rom_addr),
    .tone_wrap      (tone_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input int a);
    return DW'(a * 16);
  endfunction

  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return DW'(s >>> 1);
  endfunction

  always @(posedge clk) rom_q <= rom_val(int'(rom_addr));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard state
  int          m_addr = 0;
  logic        m_kind = 0;
  logic        m_got_read = 0;
  logic [DW-1:0] m_rd_l = '0;
  logic [DW-1:0] m_rd_r = '0;
  logic [DW-1:0] m_prev_l = '0;
  logic [DW-1:0] m_prev_r = '0;
  logic        m_wrap_exp = 0;
  logic        s_d1 = 0;
  logic        s_d2 = 0;
  logic        rst_prev = 0;
  int          n_read = 0;
  int          n_write = 0;

  // per-cycle samples for directed steps
  logic          rd_evt, wr_evt, wr_had_read, s_wrap;
  logic [DW-1:0] s_wd_l, s_wd_r;
  logic [AW-1:0] s_addr;

  task automatic monitor();
    logic [DW-1:0] h_l, h_r, e_l, e_r;
    rd_evt = read;
    wr_evt = write;
    s_wrap = tone_wrap;
    s_wd_l = writedata_left;
    s_wd_r = writedata_right;
    s_addr = rom_addr;
    wr_had_read = m_got_read;
    if (reset) begin
      chk("rst_read", read, 0);
      chk("rst_write", write, 0);
      if (rst_prev) begin
        chk("rst_addr", rom_addr, 0);
        chk("rst_wd_l", writedata_left, 0);
        chk("rst_wd_r", writedata_right, 0);
        chk("rst_wrap", tone_wrap, 0);
      end
      m_addr = 0;
      m_kind = 0;
      m_got_read = 0;
      m_wrap_exp = 0;
      m_prev_l = '0;
      m_prev_r = '0;
      s_d1 = 0;
      s_d2 = 0;
      rst_prev = 1;
      return;
    end
    rst_prev = 0;
    chk("rom_addr", rom_addr, 64'(m_addr));
    chk("tone_wrap", tone_wrap, m_wrap_exp);
    m_wrap_exp = 0;
    if (read || write) chk("rd_wr_excl", read && write, 0);
    if (read) begin
      chk("rd_ready", read_ready, 1);
      chk("rd_in_pass", m_kind, 0);
      chk("rd_once", m_got_read, 0);
      m_got_read = 1;
      m_rd_l = readdata_left;
      m_rd_r = readdata_right;
      n_read++;
    end
    if (write) begin
      chk("wr_ready", write_ready, 1);
      chk("wr_src", m_got_read, !m_kind);
      if (m_kind) begin
        h_l = rom_val(m_addr);
        h_r = h_l;
      end else begin
        h_l = m_rd_l;
        h_r = m_rd_r;
      end
`ifdef AUDIO_AVG_EN
      e_l = avg(h_l, m_prev_l);
      e_r = avg(h_r, m_prev_r);
      m_prev_l = h_l;
      m_prev_r = h_r;
`else
      e_l = h_l;
      e_r = h_r;
`endif
      chk("wd_l", writedata_left, e_l);
      chk("wd_r", writedata_right, e_r);
      if (m_kind) begin
        if (m_addr == TL - 1) begin
          m_addr = 0;
          m_wrap_exp = 1;
        end else begin
          m_addr++;
        end
      end
`ifdef AUDIO_AVG_EN
      if (s_d2 != m_kind) begin
        m_prev_l = '0;
        m_prev_r = '0;
      end
`endif
      m_kind = s_d2;
      m_got_read = 0;
      n_write++;
    end
    s_d2 = s_d1;
    s_d1 = src_sel;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nr0, nw0, nwrap, wrap_at;
    int tidx[$];
    logic [DW-1:0] tdat[$];
    logic kinds[$];
    logic [2:0] kv;
    logic [DW-1:0] tone_exp [5];
    tone_exp = '{24'd0, 24'd16, 24'd32, 24'd48, 24'd0};

    // reset with both ready lines high
    repeat (3) cyc();
    readdata_left = 24'h000123;
    readdata_right = 24'hFFFF00;
    write_ready = 0;
    reset = 0;
    nr0 = n_read;
    nw0 = n_write;
    cyc();
    chk("first_read", rd_evt, 1);

    // passthrough stall
    repeat (5) begin
      cyc();
      chk("stall_write", wr_evt, 0);
      chk("stall_read", rd_evt, 0);
`ifndef AUDIO_AVG_EN
      chk("stall_wd_l", s_wd_l, 24'h000123);
      chk("stall_wd_r", s_wd_r, 24'hFFFF00);
`endif
    end
    write_ready = 1;
    read_ready = 0;
    cyc();
    chk("pass_write", wr_evt, 1);
    cyc();
    chk("pass_nread", n_read - nr0, 1);
    chk("pass_nwrite", n_write - nw0, 1);

    // tone playback with wrap
    src_sel = 1;
    repeat (3) cyc();
    read_ready = 1;
    nwrap = 0;
    wrap_at = -1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (wr_evt && !wr_had_read) begin
        tidx.push_back(i);
        tdat.push_back(s_wd_l);
      end
      if (s_wrap) begin
        nwrap++;
        wrap_at = i;
      end
    end
    chk("tone_nwr", tidx.size(), 5);
    chk("tone_nwrap", nwrap, 1);
    for (int k = 1; k < tidx.size(); k++)
      chk("tone_period", tidx[k] - tidx[k-1], 3);
    if (tidx.size() >= 4)
      chk("wrap_at", wrap_at, tidx[3] + 1);
`ifndef AUDIO_AVG_EN
    foreach (tdat[k])
      if (k < 5) chk("tone_data", tdat[k], tone_exp[k]);
`endif

    // switch to tone while a passthrough sample sits in PUSH
    src_sel = 0;
    read_ready = 0;
    write_ready = 1;
    repeat (8) cyc();
    read_ready = 1;
    write_ready = 0;
    cyc();
    chk("sw_read", rd_evt, 1);
    src_sel = 1;
    write_ready = 1;
    repeat (6) begin
      cyc();
      if (wr_evt) kinds.push_back(wr_had_read);
    end
    chk("sw_nwr", kinds.size(), 3);
    kv = 3'b000;
    foreach (kinds[k])
      if (k < 3) kv[2-k] = kinds[k];
    chk("sw_kinds", kv, 3'b110);

    // reset while stalled in PUSH
    write_ready = 0;
    repeat (4) cyc();
    chk("pre_rst_addr", s_addr != 0, 1);
    reset = 1;
    write_ready = 1;
    cyc();
    chk("mid_rst_write", wr_evt, 0);
    reset = 0;
    write_ready = 0;
    read_ready = 0;
    cyc();
    chk("post_rst_addr", s_addr, 0);
    chk("post_rst_write", wr_evt, 0);

`ifdef AUDIO_AVG_EN
    src_sel = 0;
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    read_ready = 1;
    write_ready = 1;
    readdata_left = 24'd100;
    readdata_right = 24'd100;
    cyc();
    readdata_left = 24'd300;
    readdata_right = 24'd300;
    cyc();
    chk("avg_w1", {wr_evt, s_wd_l}, {1'b1, 24'd50});
    cyc();
    cyc();
    chk("avg_w2", {wr_evt, s_wd_l}, {1'b1, 24'd200});
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    readdata_left = -24'sd3;
    readdata_right = -24'sd3;
    cyc();
    readdata_left = -24'sd1;
    readdata_right = -24'sd1;
    cyc();
    chk("avg_w3", {wr_evt, s_wd_l}, {1'b1, -24'sd2});
    cyc();
    cyc();
    chk("avg_w4", {wr_evt, s_wd_r}, {1'b1, -24'sd2});
`endif

    // random traffic
    nw0 = n_write;
    repeat (3000) begin
      read_ready = ($urandom_range(0, 9) < 7);
      write_ready = ($urandom_range(0, 9) < 7);
      readdata_left = DW'($urandom);
      readdata_right = DW'($urandom);
      if ($urandom_range(0, 39) == 0) src_sel = ~src_sel;
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    chk("rand_progress", (n_write - nw0) > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
